// File: rtl/alu_operand_seq_if.sv
// Operand-in / result-out handshake bundle for alu_operand_seq.
// The slave modport is the sequencer side; master is the producer/consumer side.
interface alu_operand_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] res;
  logic             res_valid;
  logic             res_ack;

  modport master (
    output in_data,
    output in_valid,
    output res_ack,
    input  in_ready,
    input  res,
    input  res_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  res_ack,
    output in_ready,
    output res,
    output res_valid
  );
endinterface

// File: rtl/alu_operand_seq.sv
// Operand loader and result capture around the combinational K_ALU datapath.
// Optional result flags are built only when ALU_FLAGS_EN is defined.
module alu_operand_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_operand_seq_if.slave bus,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_res,
  output logic [1:0]       state,
  output logic [7:0]       op_count,
  output logic             flag_z,
  output logic             flag_n
);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    EXEC   = 2'b10,
    HOLD   = 2'b11
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic             load_a_s;
  logic             load_b_s;
  logic             exec_s;
  logic             in_ready_r;
  logic             res_valid_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] res_r;
  logic [7:0]       op_count_r;

  // Next-state and load strobes; in_valid is only honoured in the two load states.
  always_comb begin
    state_nx_s = state_r;
    load_a_s   = 1'b0;
    load_b_s   = 1'b0;
    exec_s     = 1'b0;
    case (state_r)
      LOAD_A: begin
        if (bus.in_valid) begin
          state_nx_s = LOAD_B;
          load_a_s   = 1'b1;
        end else begin
          state_nx_s = LOAD_A;
        end
      end
      LOAD_B: begin
        if (bus.in_valid) begin
          state_nx_s = EXEC;
          load_b_s   = 1'b1;
        end else begin
          state_nx_s = LOAD_B;
        end
      end
      EXEC: begin
        state_nx_s = HOLD;
        exec_s     = 1'b1;
      end
      HOLD: begin
        if (bus.res_ack) begin
          state_nx_s = LOAD_A;
        end else begin
          state_nx_s = HOLD;
        end
      end
      default: begin
        state_nx_s = LOAD_A;
      end
    endcase
  end

  // State, operand and result registers; handshake outputs follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= LOAD_A;
      in_ready_r  <= 1'b1;
      res_valid_r <= 1'b0;
      op_a_r      <= {WIDTH{1'b0}};
      op_b_r      <= {WIDTH{1'b0}};
      res_r       <= {WIDTH{1'b0}};
      op_count_r  <= 8'd0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == LOAD_A) || (state_nx_s == LOAD_B);
      res_valid_r <= (state_nx_s == HOLD);
      if (load_a_s) begin
        op_a_r <= bus.in_data;
      end
      if (load_b_s) begin
        op_b_r <= bus.in_data;
      end
      if (exec_s) begin
        res_r      <= alu_res;
        op_count_r <= op_count_r + 8'd1;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic flag_z_r;
  logic flag_n_r;

  // Flags are captured on the same edge as the result and held with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_r <= 1'b0;
      flag_n_r <= 1'b0;
    end else if (exec_s) begin
      flag_z_r <= (alu_res == {WIDTH{1'b0}});
      flag_n_r <= alu_res[WIDTH-1];
    end
  end

  assign flag_z = flag_z_r;
  assign flag_n = flag_n_r;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

  assign state         = state_r;
  assign op_a          = op_a_r;
  assign op_b          = op_b_r;
  assign op_count      = op_count_r;
  assign bus.in_ready  = in_ready_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res       = res_r;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Self-checking bench for alu_operand_seq with an arithmetic-right-shift ALU model.
module tb_alu_operand_seq;
  localparam int WIDTH = 8;
`ifdef ALU_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic [1:0]       state;
  logic [7:0]       op_count;
  logic             flag_z;
  logic             flag_n;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_count;
  logic [7:0] exp_res;
  logic [7:0] last_a;

  alu_operand_seq_if #(.WIDTH(WIDTH)) bus_if ();

  alu_operand_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if.slave),
    .op_a     (op_a),
    .op_b     (op_b),
    .alu_res  (alu_res),
    .state    (state),
    .op_count (op_count),
    .flag_z   (flag_z),
    .flag_n   (flag_n)
  );

  always #5 clk = ~clk;

  // Combinational shifter standing in for K_ALU
  assign alu_res = $signed(op_a) >>> op_b[2:0];

  // Reference: signed value of A divided by 2^(B mod 8), rounded toward -inf
  function automatic logic [7:0] ref_shift(input int a, input int b);
    int sa;
    int r;
    sa = (a > 127) ? a - 256 : a;
    r  = sa;
    for (int k = 0; k < (b % 8); k++) begin
      r = (r < 0 && (r % 2) != 0) ? (r - 1) / 2 : r / 2;
    end
    return 8'(r & 255);
  endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit early_ack);
    bus_if.in_data  = a;
    bus_if.in_valid = 1'b1;
    tick();
    check_value("a_state", 32'(state), 32'd1);
    check_value("a_load", 32'(op_a), 32'(a));
    bus_if.in_data = b;
    tick();
    check_value("exec_state", 32'(state), 32'd2);
    check_value("b_load", 32'(op_b), 32'(b));
    check_value("exec_valid", 32'(bus_if.res_valid), 32'd0);
    check_value("exec_ready", 32'(bus_if.in_ready), 32'd0);
    bus_if.in_valid = 1'b0;
    bus_if.res_ack  = early_ack;
    tick();
    exp_count = exp_count + 8'd1;
    exp_res   = ref_shift(int'(a), int'(b));
    last_a    = a;
    check_value("res", 32'(bus_if.res), 32'(exp_res));
    check_value("res_valid", 32'(bus_if.res_valid), 32'd1);
    check_value("hold_state", 32'(state), 32'd3);
    check_value("op_count", 32'(op_count), 32'(exp_count));
    check_value("flag_z", 32'(flag_z), 32'(FLAGS_EN && (exp_res == 8'h00)));
    check_value("flag_n", 32'(flag_n), 32'(FLAGS_EN && exp_res[7]));
  endtask

  task automatic hold_and_ack(input int hold_cycles, input bit noise);
    for (int i = 0; i < hold_cycles; i++) begin
      bus_if.res_ack  = 1'b0;
      bus_if.in_valid = noise;
      bus_if.in_data  = 8'($urandom);
      tick();
      check_value("hold_stay", 32'(state), 32'd3);
      check_value("hold_op_a", 32'(op_a), 32'(last_a));
    end
    bus_if.res_ack  = 1'b1;
    bus_if.in_valid = noise;
    bus_if.in_data  = 8'h55;
    tick();
    bus_if.res_ack  = 1'b0;
    bus_if.in_valid = 1'b0;
    check_value("ack_state", 32'(state), 32'd0);
    check_value("ack_valid", 32'(bus_if.res_valid), 32'd0);
    check_value("ack_ready", 32'(bus_if.in_ready), 32'd1);
    check_value("ack_res_kept", 32'(bus_if.res), 32'(exp_res));
    check_value("ack_op_a", 32'(op_a), 32'(last_a));
  endtask

  initial begin
    bit early;
    rst             = 1'b1;
    bus_if.in_data  = 8'h00;
    bus_if.in_valid = 1'b0;
    bus_if.res_ack  = 1'b0;
    exp_count       = 8'd0;
    exp_res         = 8'd0;
    last_a          = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    check_value("rst_state", 32'(state), 32'd0);
    check_value("rst_ready", 32'(bus_if.in_ready), 32'd1);
    check_value("rst_valid", 32'(bus_if.res_valid), 32'd0);
    check_value("rst_op_a", 32'(op_a), 32'd0);
    check_value("rst_op_b", 32'(op_b), 32'd0);
    check_value("rst_res", 32'(bus_if.res), 32'd0);
    check_value("rst_count", 32'(op_count), 32'd0);
    check_value("rst_flags", 32'({flag_z, flag_n}), 32'd0);

    // Directed shift cases
    run_op(8'hB4, 8'h02, 1'b0);
    check_value("dir_ed", 32'(bus_if.res), 32'h0000_00ED);
    hold_and_ack(0, 1'b0);
    run_op(8'h40, 8'h01, 1'b0);
    hold_and_ack(0, 1'b0);
    check_value("dir_20", 32'(bus_if.res), 32'h0000_0020);
    run_op(8'h00, 8'h05, 1'b0);
    hold_and_ack(1, 1'b0);
    run_op(8'h80, 8'h07, 1'b0);
    check_value("dir_ff", 32'(bus_if.res), 32'h0000_00FF);

    // Held strobe in HOLD, then ack colliding with in_valid
    hold_and_ack(3, 1'b1);

    // Ack while waiting for B has no effect
    bus_if.in_data  = 8'h33;
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    bus_if.res_ack  = 1'b1;
    tick();
    bus_if.res_ack = 1'b0;
    check_value("ackb_state", 32'(state), 32'd1);
    check_value("ackb_ready", 32'(bus_if.in_ready), 32'd1);
    check_value("ackb_count", 32'(op_count), 32'(exp_count));
    bus_if.in_data  = 8'h01;
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    tick();
    exp_count = exp_count + 8'd1;
    exp_res   = ref_shift(32'h33, 32'h01);
    last_a    = 8'h33;
    check_value("ackb_res", 32'(bus_if.res), 32'(exp_res));
    check_value("ackb_count2", 32'(op_count), 32'(exp_count));
    hold_and_ack(0, 1'b0);

    // Reset in the middle of an operation
    bus_if.in_data  = 8'h12;
    bus_if.in_valid = 1'b1;
    tick();
    check_value("mid_a", 32'(state), 32'd1);
    bus_if.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 8'd0;
    exp_res   = 8'd0;
    last_a    = 8'd0;
    check_value("mid_state", 32'(state), 32'd0);
    check_value("mid_op_a", 32'(op_a), 32'd0);
    check_value("mid_count", 32'(op_count), 32'd0);
    check_value("mid_ready", 32'(bus_if.in_ready), 32'd1);

    // Randomized operations through the op_count wrap
    for (int i = 0; i < 256; i++) begin
      early = 1'($urandom_range(0, 1));
      run_op(8'($urandom), 8'($urandom), early);
      if (i == 254) begin
        check_value("count_255", 32'(op_count), 32'h0000_00FF);
      end
      hold_and_ack(early ? 0 : int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    check_value("count_wrap", 32'(op_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
